// File: rtl/decode_stage_if.sv
// Fetch->decode and decode->rename valid/ready links for decode_stage.
// slave is the decode side; master is the fetch/rename environment side.
interface decode_stage_if #(
    parameter int unsigned ALU_OP_W = 4
);
    logic [31:0]         instr_in;
    logic [31:0]         pc_in;
    logic [31:0]         pc_4_in;
    logic                valid_in;
    logic                ready_in;
    logic                valid_out;
    logic                ready_out;
    logic [31:0]         pc_out;
    logic [31:0]         pc_4_out;
    logic [4:0]          rs1_out;
    logic [4:0]          rs2_out;
    logic [4:0]          rd_out;
    logic [31:0]         imm_out;
    logic [ALU_OP_W-1:0] alu_op_out;
    logic [2:0]          funct3_out;
    logic [1:0]          fu_type_out;
    logic                uses_rs1_out;
    logic                uses_rs2_out;
    logic [4:0]          ctrl_out;
    logic                writes_rd_out;

    modport master (
        output instr_in, pc_in, pc_4_in, valid_in, ready_out,
        input  ready_in, valid_out, pc_out, pc_4_out, rs1_out, rs2_out, rd_out,
               imm_out, alu_op_out, funct3_out, fu_type_out, uses_rs1_out,
               uses_rs2_out, ctrl_out, writes_rd_out
    );

    modport slave (
        input  instr_in, pc_in, pc_4_in, valid_in, ready_out,
        output ready_in, valid_out, pc_out, pc_4_out, rs1_out, rs2_out, rd_out,
               imm_out, alu_op_out, funct3_out, fu_type_out, uses_rs1_out,
               uses_rs2_out, ctrl_out, writes_rd_out
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational field decode captured into a 2-entry
// elastic buffer (output register + skid register), flushed on mispredict.
module decode_stage #(
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mispredict,
    decode_stage_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] FU_ALU    = 2'd0;
    localparam logic [1:0] FU_BRANCH = 2'd1;
    localparam logic [1:0] FU_LSU    = 2'd2;

    // ctrl bit positions: {illegal, is_store, is_load, is_jump, is_branch}
    localparam logic [4:0] CTRL_BRANCH  = 5'b00001;
    localparam logic [4:0] CTRL_JUMP    = 5'b00010;
    localparam logic [4:0] CTRL_LOAD    = 5'b00100;
    localparam logic [4:0] CTRL_STORE   = 5'b01000;
    localparam logic [4:0] CTRL_ILLEGAL = 5'b10000;

    localparam logic [ALU_OP_W-1:0] ALU_ADD      = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB      = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL      = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLT      = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU     = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_XOR      = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL      = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA      = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR       = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_AND      = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_PASS_IMM = ALU_OP_W'(10);

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     pc_4;
        logic [REGW-1:0]     rs1;
        logic [REGW-1:0]     rs2;
        logic [REGW-1:0]     rd;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          funct3;
        logic [1:0]          fu_type;
        logic                uses_rs1;
        logic                uses_rs2;
        logic [4:0]          ctrl;
        logic                writes_rd;
    } uop_t;

    uop_t dec_c;
    uop_t out_q;
    uop_t skid_q;
    logic out_valid_q;
    logic skid_valid_q;

    logic [6:0]          opcode_c;
    logic [2:0]          funct3_c;
    logic                alt_c;
    logic [XLEN-1:0]     imm_i_c;
    logic [XLEN-1:0]     imm_s_c;
    logic [XLEN-1:0]     imm_b_c;
    logic [XLEN-1:0]     imm_u_c;
    logic [XLEN-1:0]     imm_j_c;
    logic [XLEN-1:0]     shamt_c;
    logic [ALU_OP_W-1:0] alu_reg_c;
    logic [ALU_OP_W-1:0] alu_imm_c;
    logic                wr_c;
    logic                accept_c;
    logic                load_out_c;

    // Shared funct3 -> ALU op map; SUB only exists for register-register ops.
    function automatic logic [ALU_OP_W-1:0] alu_map(input logic [2:0] f3,
                                                    input logic alt,
                                                    input logic allow_sub);
        case (f3)
            3'd0:    alu_map = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_map = ALU_SLL;
            3'd2:    alu_map = ALU_SLT;
            3'd3:    alu_map = ALU_SLTU;
            3'd4:    alu_map = ALU_XOR;
            3'd5:    alu_map = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_map = ALU_OR;
            default: alu_map = ALU_AND;
        endcase
    endfunction

    // Field extraction and immediate formats.
    always_comb begin
        opcode_c  = bus.instr_in[6:0];
        funct3_c  = bus.instr_in[14:12];
        alt_c     = bus.instr_in[30];
        imm_i_c   = {{20{bus.instr_in[31]}}, bus.instr_in[31:20]};
        imm_s_c   = {{20{bus.instr_in[31]}}, bus.instr_in[31:25], bus.instr_in[11:7]};
        imm_b_c   = {{19{bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[7],
                     bus.instr_in[30:25], bus.instr_in[11:8], 1'b0};
        imm_u_c   = {bus.instr_in[31:12], 12'b0};
        imm_j_c   = {{11{bus.instr_in[31]}}, bus.instr_in[31], bus.instr_in[19:12],
                     bus.instr_in[20], bus.instr_in[30:21], 1'b0};
        shamt_c   = {27'b0, bus.instr_in[24:20]};
        alu_reg_c = alu_map(funct3_c, alt_c, 1'b1);
        alu_imm_c = alu_map(funct3_c, alt_c, 1'b0);
    end

    // Opcode decode into the micro-op payload.
    always_comb begin
        dec_c        = '0;
        wr_c         = 1'b0;
        dec_c.pc     = bus.pc_in;
        dec_c.pc_4   = bus.pc_4_in;
        dec_c.rs1    = bus.instr_in[19:15];
        dec_c.rs2    = bus.instr_in[24:20];
        dec_c.rd     = bus.instr_in[11:7];
        dec_c.funct3 = funct3_c;
        case (opcode_c)
            OPC_LUI: begin
                dec_c.imm    = imm_u_c;
                dec_c.alu_op = ALU_PASS_IMM;
                wr_c         = 1'b1;
            end
            OPC_AUIPC: begin
                dec_c.imm    = imm_u_c;
                dec_c.alu_op = ALU_ADD;
                wr_c         = 1'b1;
            end
            OPC_JAL: begin
                dec_c.imm     = imm_j_c;
                dec_c.ctrl    = CTRL_JUMP;
                dec_c.fu_type = FU_BRANCH;
                wr_c          = 1'b1;
            end
            OPC_JALR: begin
                dec_c.imm      = imm_i_c;
                dec_c.ctrl     = CTRL_JUMP;
                dec_c.fu_type  = FU_BRANCH;
                dec_c.uses_rs1 = 1'b1;
                wr_c           = 1'b1;
            end
            OPC_BRANCH: begin
                dec_c.imm      = imm_b_c;
                dec_c.ctrl     = CTRL_BRANCH;
                dec_c.fu_type  = FU_BRANCH;
                dec_c.alu_op   = ALU_OP_W'(funct3_c);
                dec_c.uses_rs1 = 1'b1;
                dec_c.uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec_c.imm      = imm_i_c;
                dec_c.ctrl     = CTRL_LOAD;
                dec_c.fu_type  = FU_LSU;
                dec_c.alu_op   = ALU_ADD;
                dec_c.uses_rs1 = 1'b1;
                wr_c           = 1'b1;
            end
            OPC_STORE: begin
                dec_c.imm      = imm_s_c;
                dec_c.ctrl     = CTRL_STORE;
                dec_c.fu_type  = FU_LSU;
                dec_c.alu_op   = ALU_ADD;
                dec_c.uses_rs1 = 1'b1;
                dec_c.uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                dec_c.imm      = (funct3_c == 3'd1 || funct3_c == 3'd5) ? shamt_c : imm_i_c;
                dec_c.alu_op   = alu_imm_c;
                dec_c.uses_rs1 = 1'b1;
                wr_c           = 1'b1;
            end
            OPC_OP: begin
                dec_c.alu_op   = alu_reg_c;
                dec_c.uses_rs1 = 1'b1;
                dec_c.uses_rs2 = 1'b1;
                wr_c           = 1'b1;
            end
            default: begin
                dec_c.ctrl = CTRL_ILLEGAL;
            end
        endcase
        dec_c.writes_rd = wr_c && (dec_c.rd != 5'd0);
    end

    assign accept_c   = bus.valid_in && !skid_valid_q && !mispredict;
    assign load_out_c = !out_valid_q || bus.ready_out;

    // Elastic buffer: skid drains first so beat order is preserved.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (mispredict) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (load_out_c) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept_c) begin
                out_q       <= dec_c;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept_c) begin
            skid_q       <= dec_c;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.ready_in      = !skid_valid_q;
    assign bus.valid_out     = out_valid_q;
    assign bus.pc_out        = out_q.pc;
    assign bus.pc_4_out      = out_q.pc_4;
    assign bus.rs1_out       = out_q.rs1;
    assign bus.rs2_out       = out_q.rs2;
    assign bus.rd_out        = out_q.rd;
    assign bus.imm_out       = out_q.imm;
    assign bus.alu_op_out    = out_q.alu_op;
    assign bus.funct3_out    = out_q.funct3;
    assign bus.fu_type_out   = out_q.fu_type;
    assign bus.uses_rs1_out  = out_q.uses_rs1;
    assign bus.uses_rs2_out  = out_q.uses_rs2;
    assign bus.ctrl_out      = out_q.ctrl;
    assign bus.writes_rd_out = out_q.writes_rd;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic, checked by a
// negedge monitor against a queue-based reference of the 2-deep buffer.
module tb_decode_stage;
    localparam int unsigned ALU_OP_W = 4;

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         pc_4;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [31:0]         imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          funct3;
        logic [1:0]          fu_type;
        logic                uses_rs1;
        logic                uses_rs2;
        logic [4:0]          ctrl;
        logic                writes_rd;
    } uop_t;

    logic clk = 1'b0;
    logic reset;
    logic mispredict;
    int   n_checks = 0;
    int   n_fail = 0;
    uop_t held[$];
    bit   armed = 1'b0;
    bit   zero_chk = 1'b0;

    decode_stage_if #(.ALU_OP_W(ALU_OP_W)) bus ();

    decode_stage #(.ALU_OP_W(ALU_OP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mispredict (mispredict),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA field rules (arithmetic on the raw word).
    function automatic uop_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] pc4);
        uop_t u;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [ALU_OP_W-1:0] tbl [8];
        logic [2:0] f3;
        logic wr;
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3 = ins[14:12];
        i_imm = 32'($signed(ins) >>> 20);
        s_imm = (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
        b_imm = (32'($signed(ins) >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11)
              | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = (32'($signed(ins) >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000)
              | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        u = '0;
        wr = 1'b0;
        u.pc = pc;
        u.pc_4 = pc4;
        u.rs1 = ins[19:15];
        u.rs2 = ins[24:20];
        u.rd = ins[11:7];
        u.funct3 = f3;
        case (ins[6:0])
            7'h37: begin u.imm = u_imm; u.alu_op = 4'd10; wr = 1; end
            7'h17: begin u.imm = u_imm; wr = 1; end
            7'h6F: begin u.imm = j_imm; u.ctrl = 5'b00010; u.fu_type = 2'd1; wr = 1; end
            7'h67: begin
                u.imm = i_imm; u.ctrl = 5'b00010; u.fu_type = 2'd1; u.uses_rs1 = 1; wr = 1;
            end
            7'h63: begin
                u.imm = b_imm; u.ctrl = 5'b00001; u.fu_type = 2'd1;
                u.uses_rs1 = 1; u.uses_rs2 = 1; u.alu_op = ALU_OP_W'(f3);
            end
            7'h03: begin
                u.imm = i_imm; u.ctrl = 5'b00100; u.fu_type = 2'd2; u.uses_rs1 = 1; wr = 1;
            end
            7'h23: begin
                u.imm = s_imm; u.ctrl = 5'b01000; u.fu_type = 2'd2;
                u.uses_rs1 = 1; u.uses_rs2 = 1;
            end
            7'h13: begin
                u.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : i_imm;
                u.alu_op = tbl[f3] + ALU_OP_W'(f3 == 3'd5 && ins[30]);
                u.uses_rs1 = 1; wr = 1;
            end
            7'h33: begin
                u.alu_op = tbl[f3] + ALU_OP_W'((f3 == 3'd0 || f3 == 3'd5) && ins[30]);
                u.uses_rs1 = 1; u.uses_rs2 = 1; wr = 1;
            end
            default: u.ctrl = 5'b10000;
        endcase
        u.writes_rd = wr && (u.rd != 5'd0);
        return u;
    endfunction

    function automatic uop_t dut_uop();
        return uop_t'({bus.pc_out, bus.pc_4_out, bus.rs1_out, bus.rs2_out, bus.rd_out,
                       bus.imm_out, bus.alu_op_out, bus.funct3_out, bus.fu_type_out,
                       bus.uses_rs1_out, bus.uses_rs2_out, bus.ctrl_out, bus.writes_rd_out});
    endfunction

    // Monitor: compare against queue head, then advance the model past the next edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("ready_in", 128'(bus.ready_in), 128'(held.size() < 2));
            chk("valid_out", 128'(bus.valid_out), 128'(held.size() > 0));
            if (held.size() > 0) chk("uop", dut_uop(), held[0]);
            else if (zero_chk) chk("reset_data", dut_uop(), '0);
        end
        if (reset || mispredict) begin
            held.delete();
            zero_chk = reset;
        end else begin
            bit acc;
            zero_chk = 1'b0;
            acc = bus.valid_in && (held.size() < 2);
            if (held.size() > 0 && bus.ready_out) void'(held.pop_front());
            if (acc) held.push_back(ref_decode(bus.instr_in, bus.pc_in, bus.pc_4_in));
        end
        if (reset) armed = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] ins, input logic [31:0] pc);
        bus.valid_in = 1'b1;
        bus.instr_in = ins;
        bus.pc_in    = pc;
        bus.pc_4_in  = pc + 32'd4;
    endtask

    logic [6:0] opcs [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    initial begin
        reset = 1'b1;
        mispredict = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_out = 1'b1;
        bus.instr_in = '0;
        bus.pc_in = '0;
        bus.pc_4_in = '0;
        step();
        step();
        chk("rst_valid_out", 128'(bus.valid_out), 128'(0));
        chk("rst_ready_in", 128'(bus.ready_in), 128'(1));
        reset = 1'b0;
        step();

        beat(32'hFFF0_0293, 32'h100);   // ADDI x5,x0,-1
        step();
        chk("addi_valid", 128'(bus.valid_out), 128'(1));
        chk("addi_rd", 128'(bus.rd_out), 128'(5));
        chk("addi_rs1", 128'(bus.rs1_out), 128'(0));
        chk("addi_imm", 128'(bus.imm_out), 128'(32'hFFFF_FFFF));
        chk("addi_alu", 128'(bus.alu_op_out), 128'(0));
        chk("addi_uses_rs1", 128'(bus.uses_rs1_out), 128'(1));
        chk("addi_wr", 128'(bus.writes_rd_out), 128'(1));
        chk("addi_pc4", 128'(bus.pc_4_out), 128'(32'h104));

        beat(32'hFE20_8CE3, 32'h104);   // BEQ x1,x2,-8
        step();
        chk("beq_imm", 128'(bus.imm_out), 128'(32'hFFFF_FFF8));
        chk("beq_ctrl", 128'(bus.ctrl_out), 128'(5'b00001));
        chk("beq_fu", 128'(bus.fu_type_out), 128'(1));
        chk("beq_uses", 128'({bus.uses_rs1_out, bus.uses_rs2_out}), 128'(2'b11));
        chk("beq_wr", 128'(bus.writes_rd_out), 128'(0));
        chk("beq_f3", 128'(bus.funct3_out), 128'(0));

        beat(32'h0000_0000, 32'h108);
        step();
        chk("zero_ctrl", 128'(bus.ctrl_out), 128'(5'b10000));
        chk("zero_wr", 128'(bus.writes_rd_out), 128'(0));
        beat(32'h0010_0013, 32'h10C);   // ADDI x0,x0,1
        step();
        chk("x0_ctrl", 128'(bus.ctrl_out), 128'(0));
        chk("x0_wr", 128'(bus.writes_rd_out), 128'(0));
        bus.valid_in = 1'b0;
        step();

        // Backpressure: A held, B in skid, C stalled by ready_in.
        bus.ready_out = 1'b0;
        beat(32'h0010_0093, 32'h200);
        step();
        chk("bp_a_pc", 128'(bus.pc_out), 128'(32'h200));
        beat(32'h0020_0113, 32'h204);
        step();
        chk("bp_ready_low", 128'(bus.ready_in), 128'(0));
        beat(32'h0030_0193, 32'h208);
        step();
        chk("bp_hold_pc", 128'(bus.pc_out), 128'(32'h200));
        bus.ready_out = 1'b1;
        step();
        chk("bp_b_pc", 128'(bus.pc_out), 128'(32'h204));
        step();
        chk("bp_c_pc", 128'(bus.pc_out), 128'(32'h208));
        bus.valid_in = 1'b0;
        step();
        chk("bp_empty", 128'(bus.valid_out), 128'(0));

        // Mispredict with skid full and a beat on the input.
        bus.ready_out = 1'b0;
        beat(32'h0010_0093, 32'h300);
        step();
        beat(32'h0020_0113, 32'h304);
        step();
        beat(32'h0030_0193, 32'h308);
        mispredict = 1'b1;
        step();
        mispredict = 1'b0;
        chk("mp_valid", 128'(bus.valid_out), 128'(0));
        chk("mp_ready", 128'(bus.ready_in), 128'(1));
        beat(32'h0040_0213, 32'h30C);
        bus.ready_out = 1'b1;
        step();
        chk("mp_next_pc", 128'(bus.pc_out), 128'(32'h30C));
        bus.valid_in = 1'b0;
        step();

        // Reset with both entries occupied.
        bus.ready_out = 1'b0;
        beat(32'h0010_0093, 32'h400);
        step();
        beat(32'h0020_0113, 32'h404);
        step();
        bus.valid_in = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_valid", 128'(bus.valid_out), 128'(0));
        chk("rst2_ready", 128'(bus.ready_in), 128'(1));
        chk("rst2_data", 128'({bus.pc_out, bus.imm_out, bus.rd_out}), 128'(0));

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] ins;
            int k;
            ins = $urandom;
            k = $urandom_range(0, 10);
            if (k < 9) ins[6:0] = opcs[k];
            bus.instr_in = ins;
            bus.pc_in = $urandom & 32'hFFFF_FFFC;
            bus.pc_4_in = bus.pc_in + 32'd4;
            bus.valid_in = ($urandom_range(0, 9) < 7);
            bus.ready_out = ($urandom_range(0, 9) < 6);
            mispredict = ($urandom_range(0, 99) < 3);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end

        bus.valid_in = 1'b0;
        bus.ready_out = 1'b1;
        mispredict = 1'b0;
        reset = 1'b0;
        repeat (4) step();
        chk("drain_empty", 128'(bus.valid_out), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Consumer end of the fetch→decode valid/ready link. Accepts {pc, pc+4, instruction} beats from fetch, decodes RV32I base integer fields into a registered micro-op, and presents it to rename over a second valid/ready link. Holds a 2-entry elastic buffer (output register plus skid register) so backpressure from rename never drops or duplicates a fetched beat. Flushes on mispredict.

Parameters:
ALU_OP_W, 4, width of alu_op_out (encoding below; values ≥11 unused)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
mispredict  input  1  flush: drop all held and incoming beats
instr_in  input  32  instruction from fetch
pc_in  input  32  PC of instr_in
pc_4_in  input  32  pc_in+4 from fetch
valid_in  input  1  fetch beat valid
ready_in  output  1  decode can accept a beat; = !skid_valid
valid_out  output  1  micro-op valid to rename
ready_out  input  1  rename accepts micro-op
pc_out  output  32  PC of micro-op
pc_4_out  output  32  PC+4 of micro-op
rs1_out  output  5  source 1 index
rs2_out  output  5  source 2 index
rd_out  output  5  destination index
imm_out  output  32  sign-extended immediate
alu_op_out  output  ALU_OP_W  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_IMM
funct3_out  output  3  raw funct3 (branch condition / memory size)
fu_type_out  output  2  0 ALU, 1 BRANCH, 2 LSU
uses_rs1_out  output  1  rs1 is a real operand
uses_rs2_out  output  1  rs2 is a real operand
ctrl_out  output  5  {illegal, is_store, is_load, is_jump, is_branch}
writes_rd_out  output  1  architectural write; forced 0 when rd==0 or illegal

Behaviour:
- Decode is combinational on instr_in; result is captured with pc_in/pc_4_in into output or skid register. All outputs registered; 1-cycle latency: beat accepted at edge N is presented immediately after edge N.
- Accept = valid_in && ready_in && !mispredict. Output register loads when !valid_out || ready_out. Priority on load: skid contents first, else incoming beat. If output register cannot load, an accepted beat goes to skid (skid_valid=1). If output drains while skid is full, skid→output and skid clears the same edge. Order preserved.
- Outputs hold stable while valid_out && !ready_out.
- Reset: valid_out=0, skid_valid=0 (ready_in=1 during and after reset), all data outputs 0. Reset mid-stream discards both entries.
- mispredict (sampled at edge): valid_out=0 and skid_valid=0 next cycle; any same-cycle input beat is dropped; ready_in=1 next cycle. mispredict with reset: reset wins, same result.
- Opcodes: LUI(0110111) U, alu PASS_IMM; AUIPC(0010111) U, ADD, fu ALU; JAL(1101111) J, is_jump, fu BRANCH; JALR(1100111) I, is_jump, uses_rs1; BRANCH(1100011) B, is_branch, uses_rs1/rs2, writes_rd=0, alu_op={0,funct3}; LOAD(0000011) I, is_load, ADD, fu LSU; STORE(0100011) S, is_store, uses_rs1/rs2, writes_rd=0, fu LSU; OP-IMM(0010011) I; OP(0110011) R, uses_rs1/rs2, imm=0.
- ALU funct3 map: 000 ADD (SUB if OP && funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND. For shift-immediate, imm_out = zero-extended shamt.
- Immediates sign-extended from instr[31]; B/J bit 0 = 0; U = {instr[31:12],12'b0}.
- Any other opcode: illegal=1, all other ctrl bits 0, uses_rs*=0, writes_rd=0, fu ALU, beat still passed downstream.

Test Plan:
- Reset then valid_in=1, instr 0xFFF00293 (ADDI x5,x0,-1) pc 0x100 -> next cycle valid_out=1, rd=5, rs1=0, imm=0xFFFFFFFF, alu ADD, uses_rs1=1, writes_rd=1, pc_4_out=0x104.
- instr 0xFE208CE3 (BEQ x1,x2,-8) -> imm=0xFFFFFFF8, is_branch=1, fu BRANCH, uses_rs1/rs2=1, writes_rd=0, funct3=000.
- ready_out=0 for 3 cycles while fetch offers beats A,B,C -> A held on output, B in skid, ready_in=0 from cycle 2, C held by fetch; ready_out=1 -> A,B,C delivered in consecutive cycles, no loss/duplicate.
- Skid full plus new valid_in, assert mispredict one cycle -> next cycle valid_out=0, ready_in=1; first post-flush beat is the next accepted one only.
- instr 0x00000000 and ADDI x0,x0,1 (0x00100013) -> first: illegal=1, writes_rd=0; second: legal, writes_rd=0.
- reset asserted while valid_out=1 and skid full -> next cycle valid_out=0, ready_in=1, all data outputs 0.
